// File: rtl/cpu_params_pkg.sv
// Core-wide sizing constants shared by the fetch/decode front end.
package cpu_params_pkg;
  localparam int XLEN          = 32;
  localparam int PC_SZ         = 32;
  localparam int FETCH_Q_DEPTH = 4;
endpackage

// File: rtl/cpu_structs_pkg.sv
// Fetch-to-decode payload types; the queue entry and decode view share one layout.
package cpu_structs_pkg;
  import cpu_params_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0]  instruction;
    logic [PC_SZ-1:0] pc;
  } IP_DATA;

  typedef struct packed {
    IP_DATA           ipd;
    logic [PC_SZ-1:0] predicted_addr;
  } Q_DATA;

  typedef struct packed {
    IP_DATA           ipd;
    logic [PC_SZ-1:0] predicted_addr;
  } FET_2_DEC;
endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: registered-flag FIFO, one-cycle
// write-to-read latency, flush for redirects. Storage is not reset.
module inst_queue
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     flush_in,
  input  logic                     wr_valid_in,
  input  Q_DATA                    wr_data_in,
  output logic                     wr_rdy_out,
  output logic                     rd_valid_out,
  output FET_2_DEC                 rd_data_out,
  input  logic                     rd_rdy_in,
  output logic [$clog2(DEPTH):0]   count_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  Q_DATA         mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Flags depend only on count, so ready/valid never see the opposite handshake.
  assign wr_rdy_out   = (count < FULL);
  assign rd_valid_out = (count != '0);
  assign count_out    = count;

  assign push = wr_valid_in & wr_rdy_out   & ~flush_in;
  assign pop  = rd_rdy_in   & rd_valid_out & ~flush_in;

  always_comb begin
    rd_data_out                 = '0;
    rd_data_out.ipd.instruction = mem[rd_ptr].ipd.instruction;
    rd_data_out.ipd.pc          = mem[rd_ptr].ipd.pc;
    rd_data_out.predicted_addr  = mem[rd_ptr].predicted_addr;
  end

  always_ff @(posedge clk_in) begin
    if (push && !reset_in) mem[wr_ptr] <= wr_data_in;
  end

  // Pointers wrap for free since DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (reset_in || flush_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue against a queue-based reference model.
module tb_inst_queue;
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;

  localparam int DEPTH = FETCH_Q_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 0, reset = 0, flush = 0, wr_valid = 0, rd_rdy = 0;
  Q_DATA         wr_data = '0;
  logic          wr_rdy, rd_valid;
  FET_2_DEC      rd_data;
  logic [CW-1:0] count;

  Q_DATA q[$];
  int errs = 0, checks = 0;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk_in(clk), .reset_in(reset), .flush_in(flush),
    .wr_valid_in(wr_valid), .wr_data_in(wr_data), .wr_rdy_out(wr_rdy),
    .rd_valid_out(rd_valid), .rd_data_out(rd_data), .rd_rdy_in(rd_rdy),
    .count_out(count)
  );

  always #5 clk = ~clk;

  function automatic Q_DATA mk(input logic [31:0] pc);
    Q_DATA d;
    d.ipd.pc          = pc;
    d.ipd.instruction = $urandom;
    d.predicted_addr  = pc + 32'h40 + {20'd0, 12'($urandom)};
    return d;
  endfunction

  // Advance one clock; the model applies queue rules to the inputs held over the edge.
  task automatic tick();
    bit    rst  = reset;
    bit    fl   = flush;
    bit    popm = (q.size() > 0) && rd_rdy;
    bit    pshm = wr_valid && (q.size() < DEPTH);
    Q_DATA d    = wr_data;
    @(posedge clk); #1;
    if (rst || fl) q.delete();
    else begin
      if (popm) void'(q.pop_front());
      if (pshm) q.push_back(d);
    end
  endtask

  task automatic push_n(input int n, input logic [31:0] pc0);
    wr_valid = 1;
    for (int i = 0; i < n; i++) begin
      wr_data = mk(pc0 + 32'(4*i));
      tick();
    end
    wr_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    checks += 3;
    if (rd_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
    if (wr_rdy !== 1'b1)   begin errs++; $display("FAIL reset_rdy: got %b want 1", wr_rdy); end
    if (count !== '0)      begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
  endtask

  task automatic test_order();
    wr_valid = 1; wr_data = mk(32'h100); tick(); wr_valid = 0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data.ipd.pc !== 32'h100) begin
      errs++; $display("FAIL order_latency: valid %b pc %h want 1 100", rd_valid, rd_data.ipd.pc);
    end
    wr_valid = 1;
    wr_data = mk(32'h104); tick();
    wr_data = mk(32'h108); tick();
    wr_valid = 0; rd_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      checks += 4;
      if (count !== CW'(3-i)) begin errs++; $display("FAIL order_count: got %0d want %0d", count, 3-i); end
      if (rd_data.ipd.pc !== 32'h100 + 32'(4*i)) begin
        errs++; $display("FAIL order_pc: got %h want %h", rd_data.ipd.pc, 32'h100 + 32'(4*i));
      end
      if (rd_data.ipd.instruction !== q[0].ipd.instruction) begin
        errs++; $display("FAIL order_instr: got %h want %h", rd_data.ipd.instruction, q[0].ipd.instruction);
      end
      if (rd_data.predicted_addr !== q[0].predicted_addr) begin
        errs++; $display("FAIL order_pred: got %h want %h", rd_data.predicted_addr, q[0].predicted_addr);
      end
      tick();
    end
    rd_rdy = 0;
    checks += 2;
    if (count !== '0)      begin errs++; $display("FAIL order_empty_count: got %0d want 0", count); end
    if (rd_valid !== 1'b0) begin errs++; $display("FAIL order_empty_valid: got %b want 0", rd_valid); end
  endtask

  task automatic test_full();
    push_n(DEPTH, 32'h200);
    checks += 2;
    if (wr_rdy !== 1'b0)      begin errs++; $display("FAIL full_rdy: got %b want 0", wr_rdy); end
    if (count !== CW'(DEPTH)) begin errs++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
    wr_valid = 1; wr_data = mk(32'hBAD0); tick();
    checks++;
    if (count !== CW'(DEPTH)) begin errs++; $display("FAIL full_ignore: got %0d want %0d", count, DEPTH); end
    // Full with pop and push together: only the pop happens.
    rd_rdy = 1; wr_data = mk(32'hBAD4); tick(); rd_rdy = 0; wr_valid = 0;
    checks += 3;
    if (wr_rdy !== 1'b1)        begin errs++; $display("FAIL full_pop_rdy: got %b want 1", wr_rdy); end
    if (count !== CW'(DEPTH-1)) begin errs++; $display("FAIL full_pop_count: got %0d want %0d", count, DEPTH-1); end
    if (rd_data.ipd.pc !== 32'h204) begin errs++; $display("FAIL full_pop_head: got %h want 204", rd_data.ipd.pc); end
    rd_rdy = 1;
    while (q.size() > 0) begin
      checks++;
      if (rd_data.ipd.pc !== q[0].ipd.pc) begin
        errs++; $display("FAIL full_drain: got %h want %h", rd_data.ipd.pc, q[0].ipd.pc);
      end
      tick();
    end
    rd_rdy = 0;
  endtask

  task automatic test_wrap();
    push_n(1, 32'h300);
    wr_valid = 1; rd_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      checks += 2;
      if (count !== CW'(1)) begin errs++; $display("FAIL wrap_count: got %0d want 1", count); end
      if (rd_data.ipd.pc !== 32'h300 + 32'(4*i)) begin
        errs++; $display("FAIL wrap_pc: got %h want %h", rd_data.ipd.pc, 32'h300 + 32'(4*i));
      end
      wr_data = mk(32'h304 + 32'(4*i));
      tick();
    end
    wr_valid = 0;
    tick(); rd_rdy = 0;
    checks++;
    if (count !== '0) begin errs++; $display("FAIL wrap_drain: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    push_n(3, 32'h400);
    flush = 1; wr_valid = 1; wr_data = mk(32'hF00); tick();
    flush = 0; wr_valid = 0;
    checks += 3;
    if (count !== '0)      begin errs++; $display("FAIL flush_count: got %0d want 0", count); end
    if (rd_valid !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b want 0", rd_valid); end
    if (wr_rdy !== 1'b1)   begin errs++; $display("FAIL flush_rdy: got %b want 1", wr_rdy); end
    push_n(1, 32'h500);
    checks++;
    if (count !== CW'(1) || rd_data.ipd.pc !== 32'h500) begin
      errs++; $display("FAIL flush_refill: count %0d pc %h want 1 500", count, rd_data.ipd.pc);
    end
    rd_rdy = 1; tick(); rd_rdy = 0;
  endtask

  task automatic test_reset_flush();
    push_n(2, 32'h600);
    reset = 1; flush = 1; tick(); reset = 0; flush = 0;
    checks += 2;
    if (count !== '0)      begin errs++; $display("FAIL rstflush_count: got %0d want 0", count); end
    if (rd_valid !== 1'b0) begin errs++; $display("FAIL rstflush_valid: got %b want 0", rd_valid); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      rd_rdy   = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 31) == 0);
      reset    = ($urandom_range(0, 63) == 0);
      wr_data  = mk($urandom);
      checks += 3;
      if (count !== CW'(q.size())) begin
        errs++; bad++; $display("FAIL rand_count: cyc %0d got %0d want %0d", c, count, q.size());
      end
      if (rd_valid !== (q.size() != 0)) begin
        errs++; bad++; $display("FAIL rand_valid: cyc %0d got %b want %b", c, rd_valid, q.size() != 0);
      end
      if (wr_rdy !== (q.size() < DEPTH)) begin
        errs++; bad++; $display("FAIL rand_rdy: cyc %0d got %b want %b", c, wr_rdy, q.size() < DEPTH);
      end
      if (q.size() > 0) begin
        checks++;
        if (rd_data.ipd.pc !== q[0].ipd.pc || rd_data.ipd.instruction !== q[0].ipd.instruction ||
            rd_data.predicted_addr !== q[0].predicted_addr) begin
          errs++; bad++; $display("FAIL rand_head: cyc %0d got %h want %h", c, rd_data, q[0]);
        end
      end
      if (bad > 10) break;
      tick();
    end
    wr_valid = 0; rd_rdy = 0; flush = 0; reset = 0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_wrap();
    test_flush();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; a power of 2 and at least 2.
REQ-002 SHALL have port clk_in, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_in, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port flush_in, input, 1 bit; 1 discards all queued entries (branch mispredict or exception redirect).
REQ-005 SHALL have port wr_valid_in, input, 1 bit; fetch presents a valid entry.
REQ-006 SHALL have port wr_data_in, input, Q_DATA (XLEN+2*PC_SZ bits), the instruction, pc and predicted_addr.
REQ-007 SHALL have port wr_rdy_out, output, 1 bit; 1 means the queue accepts an entry this cycle.
REQ-008 SHALL have port rd_valid_out, output, 1 bit; 1 means the head entry is valid for decode.
REQ-009 SHALL have port rd_data_out, output, FET_2_DEC, the head entry.
REQ-010 SHALL have port rd_rdy_in, input, 1 bit; decode consumes the head this cycle.
REQ-011 SHALL have port count_out, output, $clog2(DEPTH)+1 bits, the number of occupied entries.

Function
REQ-012 SHALL accept (push) only when wr_valid_in=1, wr_rdy_out=1 and flush_in=0.
REQ-013 SHALL consume (pop) only when rd_valid_out=1, rd_rdy_in=1 and flush_in=0.
REQ-014 SHALL drive wr_rdy_out = (count < DEPTH) from registered state only; no combinational path from rd_rdy_in or wr_valid_in.
REQ-015 SHALL drive rd_valid_out = (count != 0) from registered state only.
REQ-016 SHALL drive rd_data_out combinationally from the storage entry at rd_ptr.
REQ-017 SHALL map rd_data_out field-for-field from Q_DATA: ipd.instruction, ipd.pc and predicted_addr are passed unmodified.
REQ-018 SHALL have a write-to-read latency of 1 cycle: an entry pushed into an empty queue appears on rd_valid_out in the next cycle, with no fall-through.
REQ-019 SHALL use rd_ptr and wr_ptr of $clog2(DEPTH) bits, each incrementing modulo DEPTH and wrapping from DEPTH-1 to 0.
REQ-020 SHALL update count as follows: push only → +1; pop only → -1; push and pop together → unchanged, with both pointers advancing.
REQ-021 SHALL, when full with rd_rdy_in=1, pop but not accept a push (wr_rdy_out=0); the slot frees for the next cycle.
REQ-022 SHALL, when flush_in=1, set count, rd_ptr and wr_ptr to 0 on the next edge; flush overrides any push or pop in the same cycle.
REQ-023 SHALL, in the cycle after a flush, show rd_valid_out=0 and wr_rdy_out=1.
REQ-024 SHALL leave rd_data_out value unconstrained when rd_valid_out=0.
REQ-025 SHALL never overflow or underflow; a push while full or a pop while empty SHALL leave all state unchanged.

Reset
REQ-026 SHALL, when reset_in=1 at a rising edge, set count_out=0, rd_ptr=0 and wr_ptr=0, giving rd_valid_out=0 and wr_rdy_out=1 in the next cycle.
REQ-027 SHALL give reset priority over flush, push and pop; reset mid-stream discards all entries.
REQ-028 SHALL NOT reset the storage array; only control state is reset.

Structure
REQ-029 SHALL take the Q_DATA and FET_2_DEC typedefs from cpu_structs_pkg.
REQ-030 SHALL define the default depth as constant FETCH_Q_DEPTH in cpu_params_pkg.
REQ-031 SHALL keep storage and pointer logic inline, with no sub-module.

Verification
REQ-032 Reset case: assert reset_in for 2 cycles → rd_valid_out=0, wr_rdy_out=1, count_out=0.
REQ-033 Ordering case: push pc=0x100,0x104,0x108 with rd_rdy_in=0, then hold rd_rdy_in=1 → heads emerge as 0x100,0x104,0x108 in order, count_out goes 3,2,1,0, and the instruction and predicted_addr fields match.
REQ-034 Full case: push 4 entries (DEPTH=4) → wr_rdy_out=0 and count_out=4; a 5th wr_valid_in is ignored; one pop → wr_rdy_out=1 in the next cycle.
REQ-035 Wrap case: with steady simultaneous push and pop for 10 cycles → count stays at 1, pointers wrap, and the data sequence is intact.
REQ-036 Flush case: with 3 entries queued, flush_in=1 together with wr_valid_in=1 → next cycle count_out=0 and rd_valid_out=0, and the flushed-cycle push is not stored.
REQ-037 Reset-mid-flush case: reset_in and flush_in both high with 2 entries queued → next cycle count_out=0; random valid/ready run against a reference model shows no mismatches.
